// File: rtl/vram_sync_pkg.sv
// Shared state type, segment geometry and address width for the VRAM sync engine.
package vram_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COPY,
    ST_DRAIN,
    ST_DONE
  } vsync_state_e;

  localparam int TILRAM_DEPTH_DEF = 1024;
  localparam int PATRAM_DEPTH_DEF = 2048;
  localparam int PALRAM_DEPTH_DEF = 256;
  localparam int SPRRAM_DEPTH_DEF = 32;

  localparam int TILRAM_AW = 10;
  localparam int PATRAM_AW = 11;
  localparam int PALRAM_AW = 8;
  localparam int SPRRAM_AW = 5;

  localparam int VSYNC_ADDR_W = 11;
  localparam int VSYNC_DATA_W = 16;

  function automatic int max_depth(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/vram_sync_engine_if.sv
// CPU-facing and PPU-facing VRAM port bundles; src is the interconnect side, sync is the copy engine side.
interface vram_if_cpu_facing;
  import vram_sync_pkg::*;

  logic [TILRAM_AW-1:0]    tilram_addr_a;
  logic [PATRAM_AW-1:0]    patram_addr_a;
  logic [PALRAM_AW-1:0]    palram_addr_a;
  logic [SPRRAM_AW-1:0]    sprram_addr_a;
  logic                    tilram_wren_a;
  logic                    patram_wren_a;
  logic                    palram_wren_a;
  logic                    sprram_wren_a;
  logic [VSYNC_DATA_W-1:0] tilram_rddata_a;
  logic [VSYNC_DATA_W-1:0] patram_rddata_a;
  logic [VSYNC_DATA_W-1:0] palram_rddata_a;
  logic [VSYNC_DATA_W-1:0] sprram_rddata_a;

  modport sync (
    output tilram_addr_a, patram_addr_a, palram_addr_a, sprram_addr_a,
    output tilram_wren_a, patram_wren_a, palram_wren_a, sprram_wren_a,
    input  tilram_rddata_a, patram_rddata_a, palram_rddata_a, sprram_rddata_a
  );

  modport src (
    input  tilram_addr_a, patram_addr_a, palram_addr_a, sprram_addr_a,
    input  tilram_wren_a, patram_wren_a, palram_wren_a, sprram_wren_a,
    output tilram_rddata_a, patram_rddata_a, palram_rddata_a, sprram_rddata_a
  );
endinterface

interface vram_if_ppu_facing;
  import vram_sync_pkg::*;

  logic [TILRAM_AW-1:0]    tilram_addr_a, tilram_addr_b;
  logic [PATRAM_AW-1:0]    patram_addr_a, patram_addr_b;
  logic [PALRAM_AW-1:0]    palram_addr_a, palram_addr_b;
  logic [SPRRAM_AW-1:0]    sprram_addr_a, sprram_addr_b;
  logic [VSYNC_DATA_W-1:0] tilram_wrdata_a, tilram_wrdata_b;
  logic [VSYNC_DATA_W-1:0] patram_wrdata_a, patram_wrdata_b;
  logic [VSYNC_DATA_W-1:0] palram_wrdata_a, palram_wrdata_b;
  logic [VSYNC_DATA_W-1:0] sprram_wrdata_a, sprram_wrdata_b;
  logic                    tilram_wren_a, tilram_wren_b;
  logic                    patram_wren_a, patram_wren_b;
  logic                    palram_wren_a, palram_wren_b;
  logic                    sprram_wren_a, sprram_wren_b;

  modport sync (
    output tilram_addr_a, patram_addr_a, palram_addr_a, sprram_addr_a,
    output tilram_wrdata_a, patram_wrdata_a, palram_wrdata_a, sprram_wrdata_a,
    output tilram_wren_a, patram_wren_a, palram_wren_a, sprram_wren_a,
    output tilram_addr_b, patram_addr_b, palram_addr_b, sprram_addr_b,
    output tilram_wrdata_b, patram_wrdata_b, palram_wrdata_b, sprram_wrdata_b,
    output tilram_wren_b, patram_wren_b, palram_wren_b, sprram_wren_b
  );

  modport src (
    input tilram_addr_a, patram_addr_a, palram_addr_a, sprram_addr_a,
    input tilram_wrdata_a, patram_wrdata_a, palram_wrdata_a, sprram_wrdata_a,
    input tilram_wren_a, patram_wren_a, palram_wren_a, sprram_wren_a,
    input tilram_addr_b, patram_addr_b, palram_addr_b, sprram_addr_b,
    input tilram_wrdata_b, patram_wrdata_b, palram_wrdata_b, sprram_wrdata_b,
    input tilram_wren_b, patram_wren_b, palram_wren_b, sprram_wren_b
  );
endinterface

// File: rtl/vram_sync_delay.sv
// RD_LAT-stage shift register carrying {valid, addr} alongside the CPU-facing read latency.
module vram_sync_delay
  import vram_sync_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [VSYNC_ADDR_W-1:0] in_addr,
  output logic                    out_valid,
  output logic [VSYNC_ADDR_W-1:0] out_addr,
  output logic                    tail_empty
);

  logic [RD_LAT-1:0]       vld;
  logic [VSYNC_ADDR_W-1:0] adr [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) adr[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_addr  = adr[RD_LAT-1];

  // True when only the output stage may still hold a valid entry.
  always_comb begin
    tail_empty = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (vld[i]) tail_empty = 1'b0;
    end
  end

endmodule

// File: rtl/vram_sync_engine.sv
// Copies CPU-facing VRAM into PPU-facing VRAM during vblank, once per frame-ready request.
// state | meaning
// IDLE  | waiting for vblank_start with a pending (or same-cycle) request
// COPY  | reading addresses 0..MAX_DEPTH-1 from the shared counter
// DRAIN | reads stopped, last writes leaving the delay line
// DONE  | one-cycle completion pulse, PPU ports released
module vram_sync_engine
  import vram_sync_pkg::*;
#(
  parameter int TILRAM_DEPTH = TILRAM_DEPTH_DEF,
  parameter int PATRAM_DEPTH = PATRAM_DEPTH_DEF,
  parameter int PALRAM_DEPTH = PALRAM_DEPTH_DEF,
  parameter int SPRRAM_DEPTH = SPRRAM_DEPTH_DEF,
  parameter int RD_LAT       = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vblank,
  input  logic            vblank_start,
  input  logic            sync_req,
  output logic            sync_active,
  output logic            sync_done,
  output logic            sync_overrun,
  vram_if_cpu_facing.sync vram_ifC,
  vram_if_ppu_facing.sync vram_ifP
);

  localparam int MAX_DEPTH = max_depth(TILRAM_DEPTH, PATRAM_DEPTH, PALRAM_DEPTH, SPRRAM_DEPTH);
  localparam int CMP_W     = VSYNC_ADDR_W + 1;
  localparam logic [VSYNC_ADDR_W-1:0] LAST_ADDR = VSYNC_ADDR_W'(MAX_DEPTH - 1);

  vsync_state_e            state;
  logic [VSYNC_ADDR_W-1:0] rd_addr;
  logic                    rd_valid;
  logic                    pending;
  logic                    overrun_seen;
  logic                    start;
  logic [VSYNC_ADDR_W-1:0] wr_addr;
  logic                    wr_valid;
  logic                    tail_empty;

  assign start = (state == ST_IDLE) && vblank_start && (pending || sync_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rd_addr      <= '0;
      rd_valid     <= 1'b0;
      pending      <= 1'b0;
      overrun_seen <= 1'b0;
      sync_active  <= 1'b0;
      sync_done    <= 1'b0;
      sync_overrun <= 1'b0;
    end else begin
      sync_done    <= 1'b0;
      sync_overrun <= 1'b0;
      if (sync_req) pending <= 1'b1;
      if (sync_active && !vblank && !overrun_seen) begin
        sync_overrun <= 1'b1;
        overrun_seen <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_COPY;
            rd_addr      <= '0;
            rd_valid     <= 1'b1;
            sync_active  <= 1'b1;
            pending      <= 1'b0;
            overrun_seen <= 1'b0;
          end
        end
        ST_COPY: begin
          if (rd_addr == LAST_ADDR) begin
            state    <= ST_DRAIN;
            rd_addr  <= '0;
            rd_valid <= 1'b0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Leave as the final write sits in the output stage, so DONE sees an empty line.
          if (tail_empty) begin
            state       <= ST_DONE;
            sync_active <= 1'b0;
            sync_done   <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  vram_sync_delay #(.RD_LAT(RD_LAT)) u_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (rd_valid),
    .in_addr    (rd_addr),
    .out_valid  (wr_valid),
    .out_addr   (wr_addr),
    .tail_empty (tail_empty)
  );

  assign vram_ifC.tilram_addr_a = rd_addr[TILRAM_AW-1:0];
  assign vram_ifC.patram_addr_a = rd_addr[PATRAM_AW-1:0];
  assign vram_ifC.palram_addr_a = rd_addr[PALRAM_AW-1:0];
  assign vram_ifC.sprram_addr_a = rd_addr[SPRRAM_AW-1:0];
  assign vram_ifC.tilram_wren_a = 1'b0;
  assign vram_ifC.patram_wren_a = 1'b0;
  assign vram_ifC.palram_wren_a = 1'b0;
  assign vram_ifC.sprram_wren_a = 1'b0;

  assign vram_ifP.tilram_addr_a   = wr_addr[TILRAM_AW-1:0];
  assign vram_ifP.patram_addr_a   = wr_addr[PATRAM_AW-1:0];
  assign vram_ifP.palram_addr_a   = wr_addr[PALRAM_AW-1:0];
  assign vram_ifP.sprram_addr_a   = wr_addr[SPRRAM_AW-1:0];
  assign vram_ifP.tilram_wrdata_a = vram_ifC.tilram_rddata_a;
  assign vram_ifP.patram_wrdata_a = vram_ifC.patram_rddata_a;
  assign vram_ifP.palram_wrdata_a = vram_ifC.palram_rddata_a;
  assign vram_ifP.sprram_wrdata_a = vram_ifC.sprram_rddata_a;

  // Smaller segments stop writing once the shared address passes their depth.
  assign vram_ifP.tilram_wren_a = wr_valid && ({1'b0, wr_addr} < CMP_W'(TILRAM_DEPTH));
  assign vram_ifP.patram_wren_a = wr_valid && ({1'b0, wr_addr} < CMP_W'(PATRAM_DEPTH));
  assign vram_ifP.palram_wren_a = wr_valid && ({1'b0, wr_addr} < CMP_W'(PALRAM_DEPTH));
  assign vram_ifP.sprram_wren_a = wr_valid && ({1'b0, wr_addr} < CMP_W'(SPRRAM_DEPTH));

  assign vram_ifP.tilram_addr_b   = '0;
  assign vram_ifP.patram_addr_b   = '0;
  assign vram_ifP.palram_addr_b   = '0;
  assign vram_ifP.sprram_addr_b   = '0;
  assign vram_ifP.tilram_wren_b   = 1'b0;
  assign vram_ifP.patram_wren_b   = 1'b0;
  assign vram_ifP.palram_wren_b   = 1'b0;
  assign vram_ifP.sprram_wren_b   = 1'b0;
  assign vram_ifP.tilram_wrdata_b = '0;
  assign vram_ifP.patram_wrdata_b = '0;
  assign vram_ifP.palram_wrdata_b = '0;
  assign vram_ifP.sprram_wrdata_b = '0;

endmodule

// File: tb/tb_vram_sync_engine.sv
// Bench for vram_sync_engine: two instances (RD_LAT 1 and 2) sharing stimulus, checked against
// depth/latency arithmetic and the random CPU-side preload.
module tb_vram_sync_engine;
  import vram_sync_pkg::*;

  localparam int D_TIL = 1024;
  localparam int D_PAT = 2048;
  localparam int D_PAL = 256;
  localparam int D_SPR = 32;
  localparam int MAXD  = 2048;  // largest of the four depths
  localparam int LAT1  = 1;
  localparam int LAT2  = 2;

  logic clk, rst, vblank, vblank_start, sync_req;
  logic act1, done1, ovr1, act2, done2, ovr2;

  vram_if_cpu_facing cif1 ();
  vram_if_ppu_facing pif1 ();
  vram_if_cpu_facing cif2 ();
  vram_if_ppu_facing pif2 ();

  vram_sync_engine #(.RD_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .vblank(vblank), .vblank_start(vblank_start), .sync_req(sync_req),
    .sync_active(act1), .sync_done(done1), .sync_overrun(ovr1), .vram_ifC(cif1), .vram_ifP(pif1));

  vram_sync_engine #(.RD_LAT(LAT2)) u_dut2 (
    .clk(clk), .rst(rst), .vblank(vblank), .vblank_start(vblank_start), .sync_req(sync_req),
    .sync_active(act2), .sync_done(done2), .sync_overrun(ovr2), .vram_ifC(cif2), .vram_ifP(pif2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU-side preload and registered-read RAM models
  logic [15:0] cpu_til [D_TIL];
  logic [15:0] cpu_pat [D_PAT];
  logic [15:0] cpu_pal [D_PAL];
  logic [15:0] cpu_spr [D_SPR];
  logic [15:0] r1 [4];
  logic [15:0] r2a [4];
  logic [15:0] r2b [4];

  always @(posedge clk) begin
    r1[0]  <= cpu_til[cif1.tilram_addr_a];
    r1[1]  <= cpu_pat[cif1.patram_addr_a];
    r1[2]  <= cpu_pal[cif1.palram_addr_a];
    r1[3]  <= cpu_spr[cif1.sprram_addr_a];
    r2a[0] <= cpu_til[cif2.tilram_addr_a];
    r2a[1] <= cpu_pat[cif2.patram_addr_a];
    r2a[2] <= cpu_pal[cif2.palram_addr_a];
    r2a[3] <= cpu_spr[cif2.sprram_addr_a];
    r2b    <= r2a;
  end

  assign cif1.tilram_rddata_a = r1[0];
  assign cif1.patram_rddata_a = r1[1];
  assign cif1.palram_rddata_a = r1[2];
  assign cif1.sprram_rddata_a = r1[3];
  assign cif2.tilram_rddata_a = r2b[0];
  assign cif2.patram_rddata_a = r2b[1];
  assign cif2.palram_rddata_a = r2b[2];
  assign cif2.sprram_rddata_a = r2b[3];

  // PPU-side RAM images and activity counters, sampled mid-cycle
  logic [15:0] p1_til [D_TIL];
  logic [15:0] p1_pat [D_PAT];
  logic [15:0] p1_pal [D_PAL];
  logic [15:0] p1_spr [D_SPR];
  logic [15:0] p2_til [D_TIL];
  logic [15:0] p2_pat [D_PAT];
  logic [15:0] p2_pal [D_PAL];
  logic [15:0] p2_spr [D_SPR];
  int a1 = 0, a2 = 0, d1 = 0, d2 = 0, o1 = 0, o2 = 0, bad = 0;
  int w1 [4] = '{0, 0, 0, 0};
  int w2 [4] = '{0, 0, 0, 0};
  int first1 = 0, first2 = 0, last1 = 0, last2 = 0, dc1 = 0, dc2 = 0;

  always @(negedge clk) begin
    if (act1) a1++;
    if (act2) a2++;
    if (done1) begin d1++; dc1 = cyc; end
    if (done2) begin d2++; dc2 = cyc; end
    if (ovr1) o1++;
    if (ovr2) o2++;
    if (pif1.tilram_wren_a) begin p1_til[pif1.tilram_addr_a] = pif1.tilram_wrdata_a; w1[0]++; end
    if (pif1.patram_wren_a) begin p1_pat[pif1.patram_addr_a] = pif1.patram_wrdata_a; w1[1]++; end
    if (pif1.palram_wren_a) begin p1_pal[pif1.palram_addr_a] = pif1.palram_wrdata_a; w1[2]++; end
    if (pif1.sprram_wren_a) begin p1_spr[pif1.sprram_addr_a] = pif1.sprram_wrdata_a; w1[3]++; end
    if (pif2.tilram_wren_a) begin p2_til[pif2.tilram_addr_a] = pif2.tilram_wrdata_a; w2[0]++; end
    if (pif2.patram_wren_a) begin p2_pat[pif2.patram_addr_a] = pif2.patram_wrdata_a; w2[1]++; end
    if (pif2.palram_wren_a) begin p2_pal[pif2.palram_addr_a] = pif2.palram_wrdata_a; w2[2]++; end
    if (pif2.sprram_wren_a) begin p2_spr[pif2.sprram_addr_a] = pif2.sprram_wrdata_a; w2[3]++; end
    if (pif1.tilram_wren_a && pif1.tilram_addr_a == '0) first1 = cyc;
    if (pif2.tilram_wren_a && pif2.tilram_addr_a == '0) first2 = cyc;
    if (pif1.patram_wren_a && pif1.patram_addr_a == 11'd2047) last1 = cyc;
    if (pif2.patram_wren_a && pif2.patram_addr_a == 11'd2047) last2 = cyc;
    if (cif1.tilram_wren_a | cif1.patram_wren_a | cif1.palram_wren_a | cif1.sprram_wren_a |
        cif2.tilram_wren_a | cif2.patram_wren_a | cif2.palram_wren_a | cif2.sprram_wren_a |
        pif1.tilram_wren_b | pif1.patram_wren_b | pif1.palram_wren_b | pif1.sprram_wren_b |
        pif2.tilram_wren_b | pif2.patram_wren_b | pif2.palram_wren_b | pif2.sprram_wren_b |
        (|pif1.patram_addr_b) | (|pif1.tilram_addr_b) | (|pif2.patram_addr_b) | (|pif2.sprram_addr_b))
      bad++;
  end

  int n_cmp = 0;
  int n_err = 0;
  int s_a1, s_a2, s_d1, s_d2, s_o1, s_o2, s_bad;
  int s_w1 [4];
  int s_w2 [4];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    s_a1 = a1; s_a2 = a2; s_d1 = d1; s_d2 = d2; s_o1 = o1; s_o2 = o2; s_bad = bad;
    s_w1 = w1; s_w2 = w2;
  endtask

  task automatic fill_cpu();
    for (int i = 0; i < D_TIL; i++) cpu_til[i] = 16'($urandom);
    for (int i = 0; i < D_PAT; i++) cpu_pat[i] = 16'($urandom);
    for (int i = 0; i < D_PAL; i++) cpu_pal[i] = 16'($urandom);
    for (int i = 0; i < D_SPR; i++) cpu_spr[i] = 16'($urandom);
  endtask

  function automatic int mem_errs(input bit second);
    int e = 0;
    for (int i = 0; i < D_TIL; i++) if ((second ? p2_til[i] : p1_til[i]) !== cpu_til[i]) e++;
    for (int i = 0; i < D_PAT; i++) if ((second ? p2_pat[i] : p1_pat[i]) !== cpu_pat[i]) e++;
    for (int i = 0; i < D_PAL; i++) if ((second ? p2_pal[i] : p1_pal[i]) !== cpu_pal[i]) e++;
    for (int i = 0; i < D_SPR; i++) if ((second ? p2_spr[i] : p1_spr[i]) !== cpu_spr[i]) e++;
    return e;
  endfunction

  function automatic int any_wren();
    return int'(pif1.tilram_wren_a | pif1.patram_wren_a | pif1.palram_wren_a | pif1.sprram_wren_a |
                pif2.tilram_wren_a | pif2.patram_wren_a | pif2.palram_wren_a | pif2.sprram_wren_a);
  endfunction

  task automatic start_copy(input int gap, input bit same, output int t0);
    if (same) begin
      sync_req = 1'b1; vblank_start = 1'b1; t0 = cyc;
      tick(1);
      sync_req = 1'b0; vblank_start = 1'b0;
    end else begin
      sync_req = 1'b1;
      tick(1);
      sync_req = 1'b0;
      tick(gap - 1);
      vblank_start = 1'b1; t0 = cyc;
      tick(1);
      vblank_start = 1'b0;
    end
  endtask

  task automatic finish_copy(input string tag, input int t0, input int exp_ovr);
    int i;
    int dep [4];
    dep = '{D_TIL, D_PAT, D_PAL, D_SPR};
    i = 0;
    while (d2 == s_d2 && i < 3000) begin
      tick(1);
      i++;
    end
    tick(2);
    chk({tag, "/active_len1"}, a1 - s_a1, MAXD + LAT1);
    chk({tag, "/active_len2"}, a2 - s_a2, MAXD + LAT2);
    chk({tag, "/done_cnt1"}, d1 - s_d1, 1);
    chk({tag, "/done_cnt2"}, d2 - s_d2, 1);
    chk({tag, "/done_cyc1"}, dc1 - t0, MAXD + LAT1 + 1);
    chk({tag, "/done_cyc2"}, dc2 - t0, MAXD + LAT2 + 1);
    chk({tag, "/overrun1"}, o1 - s_o1, exp_ovr);
    chk({tag, "/overrun2"}, o2 - s_o2, exp_ovr);
    chk({tag, "/first_wr1"}, first1 - t0, 1 + LAT1);
    chk({tag, "/first_wr2"}, first2 - t0, 1 + LAT2);
    chk({tag, "/last_wr1"}, last1 - t0, MAXD + LAT1);
    chk({tag, "/last_wr2"}, last2 - t0, MAXD + LAT2);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s/wr_count1_seg%0d", tag, s), w1[s] - s_w1[s], dep[s]);
      chk($sformatf("%s/wr_count2_seg%0d", tag, s), w2[s] - s_w2[s], dep[s]);
    end
    chk({tag, "/data1"}, mem_errs(1'b0), 0);
    chk({tag, "/data2"}, mem_errs(1'b1), 0);
    chk({tag, "/static_ports"}, bad - s_bad, 0);
  endtask

  int t0;

  initial begin
    rst = 1'b1; vblank = 1'b1; vblank_start = 1'b0; sync_req = 1'b0;
    fill_cpu();
    tick(2);
    chk("reset/active1", int'(act1), 0);
    chk("reset/active2", int'(act2), 0);
    chk("reset/done", int'(done1 | done2), 0);
    chk("reset/overrun", int'(ovr1 | ovr2), 0);
    chk("reset/wren", any_wren(), 0);
    chk("reset/cpu_addr", int'(cif1.patram_addr_a), 0);
    chk("reset/ppu_addr", int'(pif2.patram_addr_a), 0);
    rst = 1'b0;
    tick(3);

    // vblank_start without any request
    snap();
    vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
    tick(4);
    chk("noreq/active", (a1 - s_a1) + (a2 - s_a2), 0);

    // request, vblank_start ten cycles later
    fill_cpu(); snap();
    start_copy(10, 1'b0, t0);
    chk("A/start1", int'(act1), 1);
    chk("A/start2", int'(act2), 1);
    finish_copy("A", t0, 0);

    // request and vblank_start in the same cycle
    tick($urandom_range(2, 8));
    fill_cpu(); snap();
    start_copy(0, 1'b1, t0);
    chk("B/start1", int'(act1), 1);
    chk("B/start2", int'(act2), 1);
    finish_copy("B", t0, 0);

    // requests during the copy, stray vblank_start, vblank ending at cycle 1000
    tick(3);
    fill_cpu(); snap();
    start_copy($urandom_range(3, 12), 1'b0, t0);
    tick(499);
    sync_req = 1'b1; tick(1); sync_req = 1'b0;
    tick(99);
    sync_req = 1'b1; tick(1); sync_req = 1'b0;
    tick(99);
    vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
    tick(299);
    vblank = 1'b0;
    finish_copy("C", t0, 1);

    // next frame: the collapsed pending request runs with no new sync_req
    vblank = 1'b1;
    tick(5);
    fill_cpu(); snap();
    vblank_start = 1'b1; t0 = cyc; tick(1); vblank_start = 1'b0;
    chk("D/start1", int'(act1), 1);
    chk("D/start2", int'(act2), 1);
    finish_copy("D", t0, 0);

    // nothing left pending
    tick(3); snap();
    vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
    tick(5);
    chk("E/idle", (a1 - s_a1) + (a2 - s_a2), 0);

    // reset at copy cycle 300 with a request queued at cycle 100
    snap();
    start_copy(5, 1'b0, t0);
    tick(99);
    sync_req = 1'b1; tick(1); sync_req = 1'b0;
    tick(199);
    chk("R/precheck_active", int'(act1 & act2), 1);
    rst = 1'b1;
    #1;
    chk("R/active1", int'(act1), 0);
    chk("R/active2", int'(act2), 0);
    chk("R/wren", any_wren(), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    snap();
    vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
    tick(5);
    chk("R/pending_cleared", (a1 - s_a1) + (a2 - s_a2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_sync_engine.md
# vram_sync_engine

Copies the full contents of CPU-facing VRAM (tile, pattern, palette, sprite segments) into PPU-facing VRAM during vertical blanking, once per CPU frame-ready request. It drives the sync-writer side of the VRAM interconnect and asserts `sync_active`, which hands the PPU-facing ports to this block for the duration of the copy. All four segments are copied in parallel from a single shared address counter, and each segment stops writing at its own depth.

## Interface
Parameters:
- `TILRAM_DEPTH`, 1024: tile RAM words.
- `PATRAM_DEPTH`, 2048: pattern RAM words.
- `PALRAM_DEPTH`, 256: palette RAM words.
- `SPRRAM_DEPTH`, 32: sprite RAM words.
- `RD_LAT`, 1: CPU-facing port-a read latency in cycles, 1..3.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `vblank`  in  1  level; high during vertical blanking.
- `vblank_start`  in  1  single-cycle pulse on the first vblank cycle.
- `sync_req`  in  1  single-cycle pulse from the CPU control register; marks the CPU frame as ready.
- `sync_active`  out  1  to `vram_interconnect`; high while this block owns the PPU-facing VRAM.
- `sync_done`  out  1  single-cycle pulse when a copy completes.
- `sync_overrun`  out  1  single-cycle pulse when vblank ends while a copy is still in progress.
- `vram_ifC`  `vram_if_cpu_facing` modport complementary to the interconnect's `.src`.
- `vram_ifP`  `vram_if_ppu_facing` modport complementary to the interconnect's `.src`.

## Operation
- `pending` flag:
  - Set by `sync_req`.
  - Cleared when the copy starts.
  - A `sync_req` arriving during COPY/DRAIN sets it again and is serviced at the next vblank. Multiple requests collapse into one.
- States: IDLE, COPY, DRAIN, DONE.
- IDLE → COPY: on `vblank_start` while (`pending` or `sync_req`). A same-cycle `sync_req` and `vblank_start` starts immediately. Load `rd_addr` = 0.
- COPY:
  - Present `rd_addr` on all four CPU-facing `*_addr_a`, truncated to each segment's address width.
  - `rd_addr` increments every cycle.
  - When `rd_addr` = MAX_DEPTH−1, where MAX_DEPTH = max of the four depths, go to DRAIN.
- Write path:
  - The address and a valid bit are delayed `RD_LAT` cycles.
  - For each segment: PPU-facing `*_addr_a` = delayed address, `*_wrdata_a` = matching CPU-facing `*_rddata_a`, and `*_wren_a` = valid AND delayed address < segment depth.
- DRAIN: hold reads idle and wait until the delay line is empty, then go to DONE.
- DONE: one cycle. `sync_done` = 1, `sync_active` = 0. Then go to IDLE.
- Signals held constant in all states:
  - CPU-facing `*_wren_a` = 0.
  - PPU-facing `*_wren_b` = 0 and `*_addr_b` = 0.
  - PPU-facing `*_wrdata_b` are don't-care.
- Vblank ending mid-copy:
  - If `vblank` = 0 while `sync_active` = 1, pulse `sync_overrun` once per copy.
  - The copy always runs to completion; it is never aborted.
- Address arithmetic is unsigned, 11 bits wide (clog2 of MAX_DEPTH). There is no wrap-around, because the counter stops at MAX_DEPTH−1.

## Timing
- Reset values: `sync_active`, `sync_done`, `sync_overrun`, all `wren` = 0; all addresses = 0; `pending` = 0; state = IDLE; delay line invalid.
- Reset is asynchronous. Asserted mid-copy, it drops `sync_active` and all `wren` immediately; the partially updated PPU VRAM is accepted.
- Start timing: `vblank_start` sampled in cycle T → `sync_active` = 1 and read address 0 presented in T+1.
- First write (address 0) in cycle T+1+RD_LAT.
- Last write (address MAX_DEPTH−1) in cycle T+MAX_DEPTH+RD_LAT.
- `sync_active` is high for exactly MAX_DEPTH+RD_LAT cycles: 2049 cycles with the default parameters.
- `sync_done` pulses in the first cycle after `sync_active` falls.
- `sync_active` is registered (glitch-free) because it selects the interconnect muxes.
- A `vblank_start` pulse outside IDLE is ignored.

## Structure
- `vram_sync_pkg` holds:
  - the state enum `vsync_state_e`;
  - the default depth constants;
  - the segment address widths;
  - the `VSYNC_ADDR_W` = 11 constant.
- Sub-module `vram_sync_delay`: a parameterized `RD_LAT`-stage shift register carrying {valid, addr}, reset to invalid.
- Top level: FSM, read counter, `pending` flag, and the per-segment write-enable compare.

## Test plan
- `sync_req`, then `vblank_start` 10 cycles later → `sync_active` is high for 2049 cycles, and every PPU-facing word equals the CPU-facing preload: patram 2048, tilram 1024, palram 256, sprram 32 words. `sync_done` pulses once.
- Write-enable cutoff by segment depth → sprram `wren_a` is high for exactly 32 cycles (addresses 0..31), tilram for 1024 cycles; no writes beyond depth.
- `vblank_start` with no pending request → `sync_active` stays 0. `sync_req` and `vblank_start` in the same cycle → copy starts the next cycle.
- `sync_req` at cycle 500 of a copy → the current copy finishes, and a second copy starts at the next `vblank_start` with no new request.
- `vblank` falls at cycle 1000 of the copy → `sync_overrun` pulses exactly once, and the copy still ends at cycle 2049 with correct data.
- `rst` asserted at cycle 300 of the copy → `sync_active` and all `wren` go to 0 immediately; after release the block is in IDLE with `pending` = 0. Repeat the full copy with RD_LAT = 2 → 2050 active cycles.
